// File: rtl/spi_transaction_controller.sv
// Transaction sequencer for the SPI memory datapath: command byte, then one data byte in or out.
// Optional address-increment burst mode is enabled by defining SPI_BURST_EN.
module spi_transaction_controller #(
  parameter int ADDR_BITS = 7,
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       pos_edge,
  input  logic       sr_rw_bit,
  output logic       addr_we,
  output logic       sr_load,
  output logic       dm_we,
  output logic       miso_oe,
  output logic       addr_inc,
  output logic       busy,
  output logic       protocol_err,
  output logic [2:0] state
);

`ifdef SPI_BURST_EN
  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    GET_ADDR   = 4'd1,
    LATCH_ADDR = 4'd2,
    READ_LOAD  = 4'd3,
    READ_SHIFT = 4'd4,
    WRITE_GET  = 4'd5,
    WRITE_MEM  = 4'd6,
    DONE       = 4'd7,
    ADDR_INC   = 4'd8
  } state_t;
  localparam state_t AFTER_DATA = ADDR_INC;
`else
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GET_ADDR   = 3'd1,
    LATCH_ADDR = 3'd2,
    READ_LOAD  = 3'd3,
    READ_SHIFT = 3'd4,
    WRITE_GET  = 3'd5,
    WRITE_MEM  = 3'd6,
    DONE       = 3'd7
  } state_t;
  localparam state_t AFTER_DATA = DONE;
`endif

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             err_q, err_d;
  logic             counting;
  logic             last_addr_edge;
  logic             last_data_edge;

  assign counting       = (state_q == GET_ADDR) || (state_q == READ_SHIFT) ||
                          (state_q == WRITE_GET);
  assign last_addr_edge = pos_edge && (bit_cnt_q == ADDR_LAST);
  assign last_data_edge = pos_edge && (bit_cnt_q == DATA_LAST);

`ifdef SPI_BURST_EN
  logic dir_q, dir_d;

  assign dir_d = (state_q == LATCH_ADDR) ? sr_rw_bit : dir_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      err_q     <= err_d;
    end
  end

  // cs_n high before the data phase has finished is an abort; it wins over any edge that cycle.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cs_n) state_d = GET_ADDR;
      end
      GET_ADDR: begin
        if (cs_n) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (last_addr_edge) begin
          state_d = LATCH_ADDR;
        end
      end
      LATCH_ADDR: begin
        if (cs_n) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (sr_rw_bit) begin
          state_d = READ_LOAD;
        end else begin
          state_d = WRITE_GET;
        end
      end
      READ_LOAD: begin
        if (cs_n) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = READ_SHIFT;
        end
      end
      READ_SHIFT: begin
        if (cs_n) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (last_data_edge) begin
          state_d = AFTER_DATA;
        end
      end
      WRITE_GET: begin
        if (cs_n) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (last_data_edge) begin
          state_d = WRITE_MEM;
        end
      end
      WRITE_MEM: begin
        state_d = cs_n ? IDLE : AFTER_DATA;
      end
      DONE: begin
        if (cs_n) state_d = IDLE;
      end
`ifdef SPI_BURST_EN
      ADDR_INC: begin
        if (cs_n) begin
          state_d = IDLE;
        end else if (dir_q) begin
          state_d = READ_LOAD;
        end else begin
          state_d = WRITE_GET;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Any state change restarts the bit count, so each counting state starts from zero.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (state_d != state_q) begin
      bit_cnt_d = '0;
    end else if (pos_edge && counting) begin
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end
  end

  assign addr_we      = (state_q == LATCH_ADDR);
  assign sr_load      = (state_q == READ_LOAD);
  assign dm_we        = (state_q == WRITE_MEM);
  assign miso_oe      = (state_q == READ_SHIFT);
  assign busy         = (state_q != IDLE);
  assign protocol_err = err_q;
  assign state        = state_q[2:0];

`ifdef SPI_BURST_EN
  assign addr_inc = (state_q == ADDR_INC);
`else
  assign addr_inc = 1'b0;
`endif

endmodule

// File: tb/tb_spi_transaction_controller.sv
// Self-checking bench for spi_transaction_controller: edge-counting transaction model plus directed literals.
// Burst scenarios run when SPI_BURST_EN is defined.
module tb_spi_transaction_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs_n;
  logic       pos_edge;
  logic       sr_rw_bit;
  logic       addr_we;
  logic       sr_load;
  logic       dm_we;
  logic       miso_oe;
  logic       addr_inc;
  logic       busy;
  logic       protocol_err;
  logic [2:0] state;

  always #5 clk = ~clk;

  spi_transaction_controller dut (
    .clk(clk),
    .reset(reset),
    .cs_n(cs_n),
    .pos_edge(pos_edge),
    .sr_rw_bit(sr_rw_bit),
    .addr_we(addr_we),
    .sr_load(sr_load),
    .dm_we(dm_we),
    .miso_oe(miso_oe),
    .addr_inc(addr_inc),
    .busy(busy),
    .protocol_err(protocol_err),
    .state(state)
  );

  int testsRun    = 0;
  int testsFailed = 0;
  bit checkEn     = 1'b0;

  int cntAddrWe, cntSrLoad, cntDmWe, cntMisoOe, cntAddrInc, cntErr;

  // Transaction model: the phase is derived from how many SCLK edges were accepted since CS fell
  // (8 command bits, 8 data bits) and how many cycles have passed since the last byte boundary.
  bit mSel, mErr, mRead;
  int mEdges, mSince;

  function automatic int modelState();
    if (!mSel) return 0;
    if (mEdges < 8) return 1;
    if (mEdges < 16) begin
      if (mSince <= 1) return 2;
      if (mRead) return (mSince == 2) ? 3 : 4;
      return 5;
    end
`ifdef SPI_BURST_EN
    if (mRead) return 8;
    return (mSince == 1) ? 6 : 8;
`else
    if (mRead) return 7;
    return (mSince == 1) ? 6 : 7;
`endif
  endfunction

  task automatic modelReset();
    mSel   = 1'b0;
    mErr   = 1'b0;
    mRead  = 1'b0;
    mEdges = 0;
    mSince = 0;
  endtask

  task automatic modelAdvance(input int s, input logic cs, input logic pe, input logic rw);
    mErr = 1'b0;
    if (mSince < 1000) mSince++;
    if (!mSel) begin
      if (!cs) begin
        mSel   = 1'b1;
        mEdges = 0;
      end
    end else if (cs) begin
      mSel = 1'b0;
      mErr = (s != 6) && (s != 7) && (s != 8);
    end else begin
      if (s == 2) mRead = rw;
      if (s == 8) begin
        mEdges = 8;
        mSince = 2;
      end else if (pe && (s == 1 || s == 4 || s == 5)) begin
        mEdges++;
        if (mEdges == 8 || mEdges == 16) mSince = 1;
      end
    end
  endtask

  // Compare DUT against the model mid-cycle, then step the model with the inputs the next edge will see.
  initial begin
    int s;
    logic [3:0] sv;
    logic [9:0] expVec, actVec;
    modelReset();
    forever begin
      @(negedge clk);
      if (reset) modelReset();
      s  = modelState();
      sv = 4'(s);
      if (checkEn) begin
        expVec = {sv[2:0], s == 2, s == 3, s == 6, s == 4, s == 8, s != 0, mErr};
        actVec = {state, addr_we, sr_load, dm_we, miso_oe, addr_inc, busy, protocol_err};
        testsRun++;
        if (actVec !== expVec) begin
          testsFailed++;
          $display("[TB] FAIL cycle_check t=%0t {state,we,ld,dm,oe,inc,busy,err}: got %b required %b",
                   $time, actVec, expVec);
        end
      end
      if (addr_we)      cntAddrWe++;
      if (sr_load)      cntSrLoad++;
      if (dm_we)        cntDmWe++;
      if (miso_oe)      cntMisoOe++;
      if (addr_inc)     cntAddrInc++;
      if (protocol_err) cntErr++;
      if (!reset) modelAdvance(s, cs_n, pos_edge, sr_rw_bit);
    end
  end

  task automatic clearCounts();
    cntAddrWe  = 0;
    cntSrLoad  = 0;
    cntDmWe    = 0;
    cntMisoOe  = 0;
    cntAddrInc = 0;
    cntErr     = 0;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs and return just after the edge that sampled them.
  task automatic applyStimulus(input logic cs, input logic pe, input logic rw);
    cs_n      = cs;
    pos_edge  = pe;
    sr_rw_bit = rw;
    @(posedge clk);
    #1;
  endtask

  task automatic sendEdges(input int n, input logic rw);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, rw);
      applyStimulus(1'b0, 1'b0, rw);
      applyStimulus(1'b0, 1'b0, rw);
      applyStimulus(1'b0, 1'b0, rw);
    end
  endtask

  initial begin
    reset     = 1'b1;
    cs_n      = 1'b1;
    pos_edge  = 1'b0;
    sr_rw_bit = 1'b0;
    clearCounts();
    checkEn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", int'(state), 0);
    checkOutput("reset_busy", int'(busy), 0);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);

    // Reset three edges into the command byte
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("cs_fall_get_addr", int'(state), 1);
    sendEdges(3, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_state", int'(state), 0);
    checkOutput("async_reset_outs",
                int'({addr_we, sr_load, dm_we, miso_oe, addr_inc, busy, protocol_err}), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("after_reset_get_addr", int'(state), 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("get_addr_abort_err", int'(protocol_err), 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("err_single_cycle", int'(protocol_err), 0);

`ifndef SPI_BURST_EN
    // Write transaction followed by stray SCLK edges in DONE
    clearCounts();
    applyStimulus(1'b0, 1'b0, 1'b0);
    sendEdges(7, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("write_latch_addr_we", int'(addr_we), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("write_get_state", int'(state), 5);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    sendEdges(7, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("write_mem_dm_we", int'(dm_we), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("write_done_state", int'(state), 7);
    sendEdges(3, 1'b0);
    checkOutput("extra_edges_done_state", int'(state), 7);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("write_end_idle", int'(state), 0);
    checkOutput("write_end_no_err", int'(protocol_err), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("write_addr_we_pulses", cntAddrWe, 1);
    checkOutput("write_dm_we_pulses", cntDmWe, 1);
    checkOutput("write_err_pulses", cntErr, 0);

    // Read transaction
    clearCounts();
    applyStimulus(1'b0, 1'b0, 1'b1);
    sendEdges(7, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("read_latch_addr_we", int'(addr_we), 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("read_sr_load", int'(sr_load), 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("read_shift_state", int'(state), 4);
    applyStimulus(1'b0, 1'b0, 1'b1);
    sendEdges(7, 1'b1);
    checkOutput("read_miso_oe_before_last", int'(miso_oe), 1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("read_miso_oe_done", int'(miso_oe), 0);
    checkOutput("read_done_state", int'(state), 7);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("read_miso_oe_cycles", cntMisoOe, 30);
    checkOutput("read_sr_load_pulses", cntSrLoad, 1);
    checkOutput("read_no_dm_we", cntDmWe, 0);
    checkOutput("read_no_err", cntErr, 0);
`endif

    // Abort five data edges into a read
    clearCounts();
    applyStimulus(1'b0, 1'b0, 1'b1);
    sendEdges(7, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    sendEdges(5, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("abort_state", int'(state), 0);
    checkOutput("abort_err", int'(protocol_err), 1);
    checkOutput("abort_miso_oe", int'(miso_oe), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("abort_err_pulses", cntErr, 1);
    checkOutput("abort_no_dm_we", cntDmWe, 0);

    // CS rising in LATCH_ADDR: latch strobe still fires, then abort
    clearCounts();
    applyStimulus(1'b0, 1'b0, 1'b0);
    sendEdges(7, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("latch_abort_err", int'(protocol_err), 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("latch_abort_addr_we", cntAddrWe, 1);

    // CS rising in WRITE_MEM: write completes without error
    clearCounts();
    applyStimulus(1'b0, 1'b0, 1'b0);
    sendEdges(8, 1'b0);
    sendEdges(7, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("wm_cs_high_idle", int'(state), 0);
    checkOutput("wm_cs_high_no_err", int'(protocol_err), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("wm_cs_high_dm_we", cntDmWe, 1);

`ifdef SPI_BURST_EN
    // Three-byte burst write under one chip select
    clearCounts();
    applyStimulus(1'b0, 1'b0, 1'b0);
    sendEdges(8, 1'b0);
    sendEdges(8, 1'b0);
    sendEdges(8, 1'b0);
    sendEdges(7, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("burst_dm_we", int'(dm_we), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("burst_addr_inc", int'(addr_inc), 1);
    checkOutput("burst_state_low_bits", int'(state), 0);
    checkOutput("burst_busy", int'(busy), 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("burst_end_idle", int'(busy), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("burst_dm_we_pulses", cntDmWe, 3);
    checkOutput("burst_addr_inc_pulses", cntAddrInc, 3);
    checkOutput("burst_no_err", cntErr, 0);
`endif

    applyStimulus(1'b1, 1'b0, 1'b0);
    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
